// File: rtl/bp_fpga_host_nbf_rx_ctrl.sv
// NBF receive controller: assembles UART bytes into {data, addr, opcode}
// packets, presents them to a consumer under io credit flow control, and
// handles fence opcodes by waiting for all io credits to return.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   rx_v_i, rx_data_i  UART byte strobe and byte
//   rx_error_i         UART framing error strobe
//   nbf_o, nbf_v_o     assembled packet and its valid (registered)
//   nbf_yumi_i         consumer accepts the packet
//   credit_return_i    one io response retired
//   fence_done_o       one-cycle pulse when a fence completes
//   error_o            one-cycle pulse when a packet or byte is dropped
module bp_fpga_host_nbf_rx_ctrl #(
    parameter int unsigned nbf_addr_width_p = 40,
    parameter int unsigned nbf_data_width_p = 64,
    parameter int unsigned timeout_cycles_p = 1000000,
    parameter int unsigned io_credits_p     = 16,
    localparam int unsigned nbf_width_lp    = 8 + nbf_addr_width_p + nbf_data_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    rx_v_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_error_i,
    output logic [nbf_width_lp-1:0] nbf_o,
    output logic                    nbf_v_o,
    input  logic                    nbf_yumi_i,
    input  logic                    credit_return_i,
    output logic                    fence_done_o,
    output logic                    error_o
);

    localparam int unsigned addr_bytes_lp   = nbf_addr_width_p / 8;
    localparam int unsigned data_bytes_lp   = nbf_data_width_p / 8;
    localparam int unsigned max_bytes_lp    = (addr_bytes_lp > data_bytes_lp) ? addr_bytes_lp : data_bytes_lp;
    localparam int unsigned cnt_width_lp    = (max_bytes_lp > 1) ? $clog2(max_bytes_lp) : 1;
    localparam int unsigned idle_width_lp   = $clog2(timeout_cycles_p + 1);
    localparam int unsigned credit_width_lp = $clog2(io_credits_p + 1);
    localparam int unsigned addr_lsb_lp     = 8;
    localparam int unsigned data_lsb_lp     = 8 + nbf_addr_width_p;
    localparam logic [7:0]  fence_op_lp     = 8'hFE;

    typedef enum logic [2:0] {
        e_opcode,
        e_addr,
        e_data,
        e_send,
        e_fence
    } state_e;

    state_e                     state_q, state_n;
    logic [cnt_width_lp-1:0]    byte_cnt_q, byte_cnt_n;
    logic [idle_width_lp-1:0]   idle_q, idle_n;
    logic [credit_width_lp-1:0] credits_q, credits_n;
    logic [nbf_width_lp-1:0]    nbf_q, nbf_n;
    logic                       nbf_v_q, nbf_v_n;
    logic                       fence_done_q, fence_done_n;
    logic                       error_q, error_n;
    logic                       credit_dec;
    logic                       in_field;

    assign nbf_o        = nbf_q;
    assign nbf_v_o      = nbf_v_q;
    assign fence_done_o = fence_done_q;
    assign error_o      = error_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_opcode;
            byte_cnt_q   <= '0;
            idle_q       <= '0;
            credits_q    <= credit_width_lp'(io_credits_p);
            nbf_q        <= '0;
            nbf_v_q      <= 1'b0;
            fence_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            byte_cnt_q   <= byte_cnt_n;
            idle_q       <= idle_n;
            credits_q    <= credits_n;
            nbf_q        <= nbf_n;
            nbf_v_q      <= nbf_v_n;
            fence_done_q <= fence_done_n;
            error_q      <= error_n;
        end
    end

    // Next-state, credit and output logic
    always_comb begin
        state_n      = state_q;
        byte_cnt_n   = byte_cnt_q;
        idle_n       = '0;
        credits_n    = credits_q;
        nbf_n        = nbf_q;
        nbf_v_n      = 1'b0;
        fence_done_n = 1'b0;
        error_n      = 1'b0;
        credit_dec   = nbf_v_q & nbf_yumi_i;
        in_field     = (state_q == e_addr) || (state_q == e_data);

        // A simultaneous accept and return cancel; returns at full are dropped.
        unique case ({credit_dec, credit_return_i})
            2'b10:   credits_n = credits_q - credit_width_lp'(1);
            2'b01:   if (credits_q != credit_width_lp'(io_credits_p))
                         credits_n = credits_q + credit_width_lp'(1);
            default: credits_n = credits_q;
        endcase

        unique case (state_q)
            e_opcode: begin
                if (rx_error_i) begin
                    error_n = 1'b1;
                end else if (rx_v_i) begin
                    nbf_n[7:0] = rx_data_i;
                    byte_cnt_n = '0;
                    state_n    = e_addr;
                end
            end

            e_addr: begin
                if (rx_error_i) begin
                    error_n = 1'b1;
                    state_n = e_opcode;
                end else if (rx_v_i) begin
                    for (int unsigned i = 0; i < addr_bytes_lp; i++) begin
                        if (byte_cnt_q == cnt_width_lp'(i))
                            nbf_n[addr_lsb_lp + 8*i +: 8] = rx_data_i;
                    end
                    if (byte_cnt_q == cnt_width_lp'(addr_bytes_lp - 1)) begin
                        byte_cnt_n = '0;
                        state_n    = e_data;
                    end else begin
                        byte_cnt_n = byte_cnt_q + cnt_width_lp'(1);
                    end
                end else if (idle_q == idle_width_lp'(timeout_cycles_p - 1)) begin
                    error_n = 1'b1;
                    state_n = e_opcode;
                end
            end

            e_data: begin
                if (rx_error_i) begin
                    error_n = 1'b1;
                    state_n = e_opcode;
                end else if (rx_v_i) begin
                    for (int unsigned i = 0; i < data_bytes_lp; i++) begin
                        if (byte_cnt_q == cnt_width_lp'(i))
                            nbf_n[data_lsb_lp + 8*i +: 8] = rx_data_i;
                    end
                    if (byte_cnt_q == cnt_width_lp'(data_bytes_lp - 1)) begin
                        byte_cnt_n = '0;
                        state_n    = e_send;
                    end else begin
                        byte_cnt_n = byte_cnt_q + cnt_width_lp'(1);
                    end
                end else if (idle_q == idle_width_lp'(timeout_cycles_p - 1)) begin
                    error_n = 1'b1;
                    state_n = e_opcode;
                end
            end

            e_send: begin
                // No buffering: bytes arriving while a packet is held are dropped.
                error_n = rx_v_i | rx_error_i;
                if (nbf_q[7:0] == fence_op_lp)
                    state_n = e_fence;
                else if (credit_dec)
                    state_n = e_opcode;
            end

            e_fence: begin
                error_n = rx_v_i | rx_error_i;
                // Look ahead at next-cycle credits so the pulse follows the last return directly.
                if (credits_n == credit_width_lp'(io_credits_p)) begin
                    fence_done_n = 1'b1;
                    state_n      = e_opcode;
                end
            end

            default: begin
                state_n = e_opcode;
            end
        endcase

        // Idle counter only runs while mid-field and resets on any byte or state change.
        if (in_field && !rx_v_i && (state_n == state_q))
            idle_n = idle_q + idle_width_lp'(1);

        // Valid is registered from next-cycle state and credits.
        nbf_v_n = (state_n == e_send) && (nbf_n[7:0] != fence_op_lp) && (credits_n != '0);
    end

endmodule

// File: tb/tb_bp_fpga_host_nbf_rx_ctrl.sv
module tb_bp_fpga_host_nbf_rx_ctrl;

    localparam int unsigned A  = 40;
    localparam int unsigned D  = 64;
    localparam int unsigned W  = 8 + A + D;
    localparam int unsigned NB = W / 8;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         rx_v_i;
    logic [7:0]   rx_data_i;
    logic         rx_error_i;
    logic [W-1:0] nbf_o;
    logic         nbf_v_o;
    logic         nbf_yumi_i;
    logic         credit_return_i;
    logic         fence_done_o;
    logic         error_o;

    int checks    = 0;
    int errors    = 0;
    int err_cnt   = 0;
    int fence_cnt = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    bp_fpga_host_nbf_rx_ctrl #(
        .nbf_addr_width_p (A),
        .nbf_data_width_p (D),
        .timeout_cycles_p (16),
        .io_credits_p     (2)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .rx_v_i          (rx_v_i),
        .rx_data_i       (rx_data_i),
        .rx_error_i      (rx_error_i),
        .nbf_o           (nbf_o),
        .nbf_v_o         (nbf_v_o),
        .nbf_yumi_i      (nbf_yumi_i),
        .credit_return_i (credit_return_i),
        .fence_done_o    (fence_done_o),
        .error_o         (error_o)
    );

    always @(negedge clk) begin
        if (error_o === 1'b1)      err_cnt++;
        if (fence_done_o === 1'b1) fence_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_pkt(input logic [7:0] op);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return {r[W-1:8], op};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_v_i    = 1'b1;
        rx_data_i = b;
        tick();
        rx_v_i    = 1'b0;
        rx_data_i = 8'h00;
    endtask

    task automatic send_bytes(input logic [W-1:0] p, input int n);
        for (int i = 0; i < n; i++) send_byte(p[i*8 +: 8]);
    endtask

    task automatic send_pkt(input logic [W-1:0] p);
        send_bytes(p, NB);
        if (p[7:0] != 8'hFE) sb.push_back(p);
    endtask

    task automatic ret_credit();
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && nbf_v_o !== 1'b1; i++) tick();
        check({tag, "_valid"}, W'(nbf_v_o), W'(1));
    endtask

    task automatic accept(input string tag, input bit with_ret);
        logic [W-1:0] exp;
        exp = 'x;
        wait_valid(tag);
        if (sb.size() > 0) exp = sb.pop_front();
        check({tag, "_data"}, nbf_o, exp);
        nbf_yumi_i      = 1'b1;
        credit_return_i = with_ret;
        tick();
        nbf_yumi_i      = 1'b0;
        credit_return_i = 1'b0;
        check({tag, "_drop"}, W'(nbf_v_o), W'(0));
    endtask

    initial begin
        logic [7:0]   b37[NB];
        logic [W-1:0] p;
        int           e0;

        reset_i         = 1'b1;
        rx_v_i          = 1'b0;
        rx_data_i       = 8'h00;
        rx_error_i      = 1'b0;
        nbf_yumi_i      = 1'b0;
        credit_return_i = 1'b0;
        repeat (3) tick();
        check("rst_v",     W'(nbf_v_o),      W'(0));
        check("rst_nbf",   nbf_o,            '0);
        check("rst_err",   W'(error_o),      W'(0));
        check("rst_fence", W'(fence_done_o), W'(0));
        reset_i = 1'b0;
        tick();

        // Known byte stream and its packet
        b37 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'hEF, 8'hBE,
                8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < NB; i++) send_byte(b37[i]);
        sb.push_back({64'h00000000DEADBEEF, 40'h0080000000, 8'h02});
        repeat (3) tick();
        check("known_hold_v", W'(nbf_v_o), W'(1));
        accept("known", 1'b0);
        ret_credit();

        // Credit exhaustion with two credits
        send_pkt(rand_pkt(8'h01)); accept("cr_a", 1'b0);
        send_pkt(rand_pkt(8'h03)); accept("cr_b", 1'b0);
        send_pkt(rand_pkt(8'h05));
        repeat (3) tick();
        check("cr_c_held", W'(nbf_v_o), W'(0));
        ret_credit();
        check("cr_c_release", W'(nbf_v_o), W'(1));
        accept("cr_c", 1'b0);
        ret_credit();
        ret_credit();

        // Fence waits for the outstanding credit
        send_pkt(rand_pkt(8'h07)); accept("pre_fence", 1'b0);
        send_pkt(rand_pkt(8'hFE));
        repeat (4) tick();
        check("fence_no_v",    W'(nbf_v_o),      W'(0));
        check("fence_wait",    W'(fence_done_o), W'(0));
        check("fence_cnt0",    W'(fence_cnt),    W'(0));
        ret_credit();
        check("fence_pulse",   W'(fence_done_o), W'(1));
        tick();
        check("fence_end",     W'(fence_done_o), W'(0));
        check("fence_cnt1",    W'(fence_cnt),    W'(1));

        // Inter-byte timeout
        send_bytes(rand_pkt(8'h33), 5);
        repeat (15) tick();
        check("to_early", W'(error_o), W'(0));
        tick();
        check("to_pulse", W'(error_o), W'(1));
        tick();
        check("to_once",  W'(error_o), W'(0));
        send_pkt(rand_pkt(8'h44)); accept("after_to", 1'b0);
        ret_credit();

        // Framing error mid-packet
        send_bytes(rand_pkt(8'h55), 3);
        rx_error_i = 1'b1;
        tick();
        rx_error_i = 1'b0;
        check("rxerr_pulse", W'(error_o), W'(1));
        tick();
        check("rxerr_once",  W'(error_o), W'(0));
        send_pkt(rand_pkt(8'h66)); accept("after_rxerr", 1'b0);
        ret_credit();

        // Bytes arriving while a packet is held are dropped
        p = rand_pkt(8'h11);
        send_pkt(p);
        wait_valid("hold");
        send_byte(8'hAA);
        check("hold_err",  W'(error_o), W'(1));
        check("hold_nbf",  nbf_o,       p);
        check("hold_v",    W'(nbf_v_o), W'(1));
        rx_error_i = 1'b1;
        tick();
        rx_error_i = 1'b0;
        check("hold_err2", W'(error_o), W'(1));
        check("hold_nbf2", nbf_o,       p);
        accept("hold", 1'b0);
        ret_credit();

        // Saturating returns and simultaneous accept/return
        ret_credit();
        ret_credit();
        send_pkt(rand_pkt(8'h21)); accept("sim_a", 1'b1);
        send_pkt(rand_pkt(8'h22)); accept("sim_b", 1'b0);
        send_pkt(rand_pkt(8'h23)); accept("sim_c", 1'b0);
        send_pkt(rand_pkt(8'h24));
        repeat (3) tick();
        check("sim_d_held", W'(nbf_v_o), W'(0));
        ret_credit();
        accept("sim_d", 1'b0);
        ret_credit();
        ret_credit();

        // Reset mid-packet with one credit outstanding
        send_pkt(rand_pkt(8'h31)); accept("pre_rst", 1'b0);
        send_bytes(rand_pkt(8'h32), 7);
        e0 = err_cnt;
        reset_i = 1'b1;
        tick();
        check("mrst_v",     W'(nbf_v_o),      W'(0));
        check("mrst_nbf",   nbf_o,            '0);
        check("mrst_err",   W'(error_o),      W'(0));
        check("mrst_fence", W'(fence_done_o), W'(0));
        reset_i = 1'b0;
        tick();
        check("mrst_silent", W'(err_cnt), W'(e0));
        send_pkt(rand_pkt(8'h41)); accept("post_rst_a", 1'b0);
        send_pkt(rand_pkt(8'h42)); accept("post_rst_b", 1'b0);
        send_pkt(rand_pkt(8'h43));
        repeat (3) tick();
        check("post_rst_held", W'(nbf_v_o), W'(0));
        ret_credit();
        accept("post_rst_c", 1'b0);
        check("sb_empty", W'(sb.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fpga_host_nbf_rx_ctrl.md
BP_FPGA_HOST_NBF_RX_CTRL -- requirements
Module: bp_fpga_host_nbf_rx_ctrl

Interface
REQ-001 SHALL have parameter nbf_addr_width_p, default 40, meaning NBF address field width in bits, a multiple of 8.
REQ-002 SHALL have parameter nbf_data_width_p, default 64, meaning NBF data field width in bits, a multiple of 8.
REQ-003 SHALL have parameter timeout_cycles_p, default 1000000, meaning the maximum idle cycles between bytes of one packet.
REQ-004 SHALL have parameter io_credits_p, default 16, meaning the maximum number of outstanding io commands.
REQ-005 SHALL define nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p (112 at defaults).
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 reset_i  input  1  reset; synchronous and active-high.
REQ-008 rx_v_i  input  1  one-cycle strobe: a UART byte is valid.
REQ-009 rx_data_i  input  8  UART byte.
REQ-010 rx_error_i  input  1  one-cycle strobe: UART framing error.
REQ-011 nbf_o  output  nbf_width_lp  packet {data, addr, opcode}; opcode is bits [7:0].
REQ-012 nbf_v_o  output  1  packet valid.
REQ-013 nbf_yumi_i  input  1  consumer accepts the packet; asserted only while nbf_v_o=1.
REQ-014 credit_return_i  input  1  one io response retired; returns one credit.
REQ-015 fence_done_o  output  1  one-cycle pulse when a fence completes.
REQ-016 error_o  output  1  one-cycle pulse when a packet is dropped.

Function
REQ-017 Byte order SHALL be: opcode, then addr bytes LSB-first, then data bytes LSB-first (1 + A + D bytes; 14 at defaults).
REQ-018 FSM states SHALL be e_opcode, e_addr, e_data, e_send, e_fence.
REQ-019 e_opcode: on rx_v_i, latch opcode and go to e_addr; byte counter cleared.
REQ-020 e_addr/e_data: each rx_v_i stores the byte at position counter*8; on the last byte of the field, advance to the next state (e_data, then e_send).
REQ-021 e_send SHALL drive nbf_v_o=1 only when opcode≠8'hFE and credits_available>0; on nbf_yumi_i, return to e_opcode.
REQ-022 Opcode 8'hFE (fence) SHALL enter e_fence from e_send without asserting nbf_v_o.
REQ-023 e_fence: when credits_available==io_credits_p, pulse fence_done_o for one cycle and return to e_opcode.
REQ-024 nbf_o SHALL hold stable while nbf_v_o=1.
REQ-025 credits_available: decrement on nbf_v_o&nbf_yumi_i; increment on credit_return_i; unchanged when both occur in one cycle.
REQ-026 credit_return_i at credits_available==io_credits_p SHALL be ignored (saturate); the counter never wraps.
REQ-027 rx_error_i in any state except e_send/e_fence SHALL discard the partial packet, pulse error_o, and go to e_opcode.
REQ-028 rx_v_i or rx_error_i during e_send/e_fence (no buffering) SHALL pulse error_o; the byte is dropped and the held packet is kept.
REQ-029 In e_addr/e_data, timeout_cycles_p consecutive cycles without rx_v_i SHALL discard the packet, pulse error_o, and go to e_opcode.
REQ-030 The idle counter SHALL clear on every rx_v_i and on every state change.
REQ-031 The module SHALL have no combinational path from inputs to nbf_v_o other than via credits/state registers; nbf_o SHALL be registered.

Reset
REQ-032 On reset_i, the block SHALL enter state e_opcode.
REQ-033 On reset_i, the byte counter, idle counter and nbf_o SHALL be 0.
REQ-034 On reset_i, credits_available SHALL be io_credits_p.
REQ-035 On reset_i, nbf_v_o, fence_done_o and error_o SHALL be 0.
REQ-036 Reset asserted mid-packet or mid-fence SHALL abandon the packet silently, with no error_o pulse.

Verification
REQ-037 Send 14 bytes 02,00,00,00,80,00,EF,BE,AD,DE,00,00,00,00 -> nbf_o = {64'h00000000DEADBEEF, 40'h0080000000, 8'h02}, nbf_v_o=1 until yumi.
REQ-038 io_credits_p=2: send 3 packets with no credit_return_i -> only 2 are accepted; the third is held with nbf_v_o=0; one credit_return_i -> nbf_v_o=1 next cycle.
REQ-039 Send FE plus 13 bytes with 1 credit outstanding -> no nbf_v_o; fence_done_o pulses one cycle after credit_return_i.
REQ-040 timeout_cycles_p=16: send 5 bytes then stall 16 cycles -> error_o pulses once; the next byte is treated as an opcode.
REQ-041 rx_error_i after 3 bytes -> error_o pulses and the state returns to e_opcode; a byte arriving during e_send -> error_o pulses and nbf_o is unchanged.
REQ-042 Simultaneous nbf_yumi_i and credit_return_i -> credits unchanged; reset after 7 bytes -> all outputs 0 and credits restored.
